// File: rtl/wb_pkg.sv
// wb_pkg: shared types and constants for the writeback arbiter
package wb_pkg;
  localparam logic [4:0] REG_X0 = 5'd0;
  typedef struct packed {
    logic        live;
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_req_t;
endpackage

// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if: ALU/LSU result streams, register-file write port and hazard lookup
interface wb_arbiter_if #(parameter int DEPTH = 4);
  logic                         alu_valid;
  logic [4:0]                   alu_rd;
  logic [31:0]                  alu_data;
  logic                         lsu_valid;
  logic                         lsu_ready;
  logic [4:0]                   lsu_rd;
  logic [31:0]                  lsu_data;
  logic                         rd_wren;
  logic [4:0]                   rd_addr;
  logic [31:0]                  rd_data;
  logic [4:0]                   rs1_addr;
  logic [4:0]                   rs2_addr;
  logic                         rs1_pending;
  logic                         rs2_pending;
  logic [$clog2(DEPTH+1)-1:0]   fifo_count;
  modport master (
    output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data, rs1_addr, rs2_addr,
    input  lsu_ready, rd_wren, rd_addr, rd_data, rs1_pending, rs2_pending, fifo_count
  );
  modport slave (
    input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data, rs1_addr, rs2_addr,
    output lsu_ready, rd_wren, rd_addr, rd_data, rs1_pending, rs2_pending, fifo_count
  );
endinterface

// File: rtl/wb_fifo.sv
// wb_fifo: LSU result queue with per-rd squash and a flattened rd/live view
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       push,
  input  wb_req_t                    push_req,
  input  logic                       pop,
  input  logic                       squash,
  input  logic [4:0]                 squash_rd,
  output wb_req_t                    head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [DEPTH*5-1:0]         view_rd,
  output logic [DEPTH-1:0]           view_live
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  wb_req_t mem [DEPTH];
  logic [AW-1:0] wp, rp;
  assign head = mem[rp];
  always_comb begin
    view_rd = '0;
    view_live = '0;
    for (int i = 0; i < DEPTH; i++) begin
      view_rd[i*5 +: 5] = mem[i].rd;
      view_live[i] = mem[i].live;
    end
  end
  // an entry pushed alongside a squash to the same rd is born dead
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      mem <= '{default: '0};
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (squash && mem[i].rd == squash_rd) mem[i].live <= 1'b0;
      if (pop) mem[rp].live <= 1'b0;
      if (push) mem[wp] <= wb_req_t'{live: push_req.live && !(squash && push_req.rd == squash_rd),
                                      rd: push_req.rd, data: push_req.data};
      wp <= push ? wp + AW'(1) : wp;
      rp <= pop ? rp + AW'(1) : rp;
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: merges ALU and LSU results onto the register-file write port
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic         i_clk,
  input logic         i_reset,
  wb_arbiter_if.slave bus
);
  localparam int CW = $clog2(DEPTH+1);
  logic alu_wr, lsu_fire, lsu_live, empty, bypass, push, pop, hit1, hit2;
  wb_req_t head, src, out_q;
  logic [CW-1:0] count;
  logic [DEPTH*5-1:0] view_rd;
  logic [DEPTH-1:0] view_live;
  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk(i_clk), .i_reset(i_reset),
    .push(push), .push_req(wb_req_t'{live: 1'b1, rd: bus.lsu_rd, data: bus.lsu_data}),
    .pop(pop), .squash(alu_wr), .squash_rd(bus.alu_rd),
    .head(head), .count(count), .view_rd(view_rd), .view_live(view_live)
  );
  assign bus.lsu_ready = count < CW'(DEPTH);
  always_comb begin
    alu_wr = bus.alu_valid && bus.alu_rd != REG_X0;
    lsu_fire = bus.lsu_valid && bus.lsu_ready;
    lsu_live = lsu_fire && bus.lsu_rd != REG_X0;
    empty = count == '0;
    bypass = lsu_live && empty && !alu_wr;
    push = lsu_live && !bypass;
    pop = !alu_wr && !empty;
    src = alu_wr ? wb_req_t'{live: 1'b1, rd: bus.alu_rd, data: bus.alu_data}
        : pop    ? head
        :          wb_req_t'{live: bypass, rd: bus.lsu_rd, data: bus.lsu_data};
    hit1 = 1'b0;
    hit2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      hit1 = hit1 | (view_live[i] && view_rd[i*5 +: 5] == bus.rs1_addr);
      hit2 = hit2 | (view_live[i] && view_rd[i*5 +: 5] == bus.rs2_addr);
    end
  end
  // address and data only move on a real write so idle and squashed slots hold them
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      out_q <= '0;
    end else begin
      out_q.live <= src.live;
      if (src.live) begin
        out_q.rd <= src.rd;
        out_q.data <= src.data;
      end
    end
  end
  assign bus.rd_wren = out_q.live;
  assign bus.rd_addr = out_q.rd;
  assign bus.rd_data = out_q.data;
  assign bus.fifo_count = count;
  assign bus.rs1_pending = bus.rs1_addr != REG_X0 && (hit1 || (out_q.live && out_q.rd == bus.rs1_addr));
  assign bus.rs2_pending = bus.rs2_addr != REG_X0 && (hit2 || (out_q.live && out_q.rd == bus.rs2_addr));
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed checks of priority, bypass, queueing, squash, x0 and reset
module tb_wb_arbiter;
  logic i_clk = 1'b0;
  logic i_reset = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  wb_arbiter_if #(.DEPTH(4)) bus ();
  wb_arbiter #(.DEPTH(4)) dut (.i_clk(i_clk), .i_reset(i_reset), .bus(bus.slave));
  always #5 i_clk = ~i_clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask
  task automatic idle();
    bus.alu_valid = 1'b0;
    bus.lsu_valid = 1'b0;
  endtask
  task automatic alu(input logic [4:0] rd, input logic [31:0] d);
    bus.alu_valid = 1'b1;
    bus.alu_rd = rd;
    bus.alu_data = d;
  endtask
  task automatic lsu(input logic [4:0] rd, input logic [31:0] d);
    bus.lsu_valid = 1'b1;
    bus.lsu_rd = rd;
    bus.lsu_data = d;
  endtask
  task automatic wr(input string tag, input logic en, input logic [4:0] a, input logic [31:0] d);
    check({tag, "_wren"}, 32'(bus.rd_wren), 32'(en));
    check({tag, "_addr"}, 32'(bus.rd_addr), 32'(a));
    check({tag, "_data"}, bus.rd_data, d);
  endtask
  initial begin
    int cnt_exp [5] = '{3, 3, 2, 1, 0};
    bus.alu_valid = 0; bus.alu_rd = 0; bus.alu_data = 0;
    bus.lsu_valid = 0; bus.lsu_rd = 0; bus.lsu_data = 0;
    bus.rs1_addr = 5; bus.rs2_addr = 0;
    tick(); tick();
    wr("rst", 0, 0, 0);
    check("rst_count", 32'(bus.fifo_count), 0);
    check("rst_ready", 32'(bus.lsu_ready), 1);
    check("rst_pend1", 32'(bus.rs1_pending), 0);
    i_reset = 1'b1;
    tick();
    alu(5, 32'h0000_1234);
    #1 check("alu_pend_before", 32'(bus.rs1_pending), 0);
    tick(); idle();
    wr("alu", 1, 5, 32'h0000_1234);
    check("alu_pend_n1", 32'(bus.rs1_pending), 1);
    tick();
    wr("alu_idle", 0, 5, 32'h0000_1234);
    check("alu_pend_n2", 32'(bus.rs1_pending), 0);
    lsu(7, 32'hDEAD_BEEF);
    #1 check("byp_ready", 32'(bus.lsu_ready), 1);
    tick(); idle();
    wr("byp", 1, 7, 32'hDEAD_BEEF);
    check("byp_count", 32'(bus.fifo_count), 0);
    bus.rs2_addr = 4;
    alu(3, 32'h33); lsu(4, 32'h44);
    tick(); idle();
    wr("col_alu", 1, 3, 32'h33);
    check("col_count1", 32'(bus.fifo_count), 1);
    check("col_pend2_n1", 32'(bus.rs2_pending), 1);
    tick();
    wr("col_lsu", 1, 4, 32'h44);
    check("col_count2", 32'(bus.fifo_count), 0);
    check("col_pend2_n2", 32'(bus.rs2_pending), 1);
    tick();
    check("col_wren_n3", 32'(bus.rd_wren), 0);
    check("col_pend2_n3", 32'(bus.rs2_pending), 0);
    for (int k = 0; k < 8; k++) begin
      alu(1, 32'(k));
      lsu(5'(10 + (k < 4 ? k : 4)), 32'h100 + 32'(10 + (k < 4 ? k : 4)));
      #1 check($sformatf("bp_ready%0d", k), 32'(bus.lsu_ready), 32'(k < 4));
      tick();
      check($sformatf("bp_addr%0d", k), 32'(bus.rd_addr), 1);
    end
    check("bp_full_count", 32'(bus.fifo_count), 4);
    check("bp_last_data", bus.rd_data, 7);
    bus.alu_valid = 1'b0;
    for (int j = 0; j < 5; j++) begin
      bus.lsu_valid = (j < 2);
      bus.lsu_rd = 14; bus.lsu_data = 32'h100 + 14;
      if (j < 2) #1 check($sformatf("drain_ready%0d", j), 32'(bus.lsu_ready), 32'(j == 1));
      tick();
      wr($sformatf("drain%0d", j), 1, 5'(10 + j), 32'h100 + 32'(10 + j));
      check($sformatf("drain_count%0d", j), 32'(bus.fifo_count), 32'(cnt_exp[j]));
    end
    idle(); tick();
    check("drain_idle", 32'(bus.rd_wren), 0);
    bus.rs1_addr = 9;
    alu(2, 32'h22); lsu(9, 32'hAA);
    tick(); idle();
    wr("sq_a", 1, 2, 32'h22);
    check("sq_count_a", 32'(bus.fifo_count), 1);
    check("sq_pend_a", 32'(bus.rs1_pending), 1);
    alu(9, 32'hBB);
    tick(); idle();
    wr("sq_b", 1, 9, 32'hBB);
    check("sq_count_b", 32'(bus.fifo_count), 1);
    check("sq_pend_b", 32'(bus.rs1_pending), 1);
    tick();
    wr("sq_c", 0, 9, 32'hBB);
    check("sq_count_c", 32'(bus.fifo_count), 0);
    check("sq_pend_c", 32'(bus.rs1_pending), 0);
    alu(6, 32'h66); lsu(6, 32'h77);
    tick(); idle();
    wr("sq_same", 1, 6, 32'h66);
    check("sq_same_count", 32'(bus.fifo_count), 1);
    tick();
    wr("sq_same_pop", 0, 6, 32'h66);
    check("sq_same_count2", 32'(bus.fifo_count), 0);
    alu(0, 32'h55); lsu(0, 32'h56);
    #1 check("x0_ready", 32'(bus.lsu_ready), 1);
    tick(); idle();
    wr("x0_both", 0, 6, 32'h66);
    check("x0_count", 32'(bus.fifo_count), 0);
    alu(0, 32'h57); lsu(8, 32'h88);
    tick(); idle();
    wr("x0_alu_lsu8", 1, 8, 32'h88);
    bus.rs1_addr = 20;
    for (int k = 0; k < 3; k++) begin
      alu(1, 32'h10 + 32'(k)); lsu(5'(20 + k), 32'h200 + 32'(k));
      tick();
    end
    check("mid_count", 32'(bus.fifo_count), 3);
    check("mid_pend", 32'(bus.rs1_pending), 1);
    idle();
    #2 i_reset = 1'b0;
    #1;
    wr("mid_rst", 0, 0, 0);
    check("mid_rst_count", 32'(bus.fifo_count), 0);
    check("mid_rst_ready", 32'(bus.lsu_ready), 1);
    check("mid_rst_pend", 32'(bus.rs1_pending), 0);
    #2 i_reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("post_rst_wren%0d", k), 32'(bus.rd_wren), 0);
      check($sformatf("post_rst_count%0d", k), 32'(bus.fifo_count), 0);
    end
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter driving the single write port of the 32×32 RV32I register file. It merges two result streams onto that port: a fixed-priority ALU stream that is never back-pressured, and a ready/valid LSU load-return stream. Losing LSU results are buffered in a small FIFO. The block also reports, per read address, whether a write is still in flight so the hazard logic can stall.

## Interface
- DEPTH, 4, LSU buffer entries; power of two, ≥2
- i_clk  in  1  clock, rising edge
- i_reset  in  1  asynchronous, active-low reset
- i_alu_valid  in  1  ALU result present this cycle
- i_alu_rd  in  5  ALU destination register
- i_alu_data  in  32  ALU result
- i_lsu_valid  in  1  LSU load result present
- o_lsu_ready  out  1  LSU result accepted when valid && ready
- i_lsu_rd  in  5  load destination register
- i_lsu_data  in  32  load data
- o_rd_wren  out  1  register-file write enable (registered)
- o_rd_addr  out  5  register-file write address (registered)
- o_rd_data  out  32  register-file write data (registered)
- i_rs1_addr, i_rs2_addr  in  5 each  decode-stage read addresses
- o_rs1_pending, o_rs2_pending  out  1 each  write to that address still in flight
- o_fifo_count  out  $clog2(DEPTH+1)  occupied FIFO entries

## Operation
- **ALU priority:** an ALU result with valid=1 and rd≠0 always owns the output register on the next edge.
- **LSU handshake:** o_lsu_ready = (count < DEPTH). It depends only on count, not on same-cycle dequeue. A transfer occurs when valid && ready.
- **LSU bypass:** the accepted LSU result goes directly to the output register when the FIFO is empty and there is no ALU write this cycle. Otherwise it is enqueued.
- **Drain:** in any cycle with no ALU write and a non-empty FIFO, the head is popped to the output register. The popped entry's live bit drives o_rd_wren.
- **Simultaneous events:** enqueue and dequeue in the same cycle are allowed and leave count unchanged.
- **x0 handling:** rd=0 on either stream produces no write. An LSU rd=0 result is accepted when ready and then discarded, never enqueued.
- **Ordering:** an LSU result is older than any ALU result presented in the same or a later cycle. An ALU write to rd=R clears the live bit of every queued entry with rd=R, including the one enqueued in that same cycle. Squashed entries are still popped in order, take a drain slot, produce o_rd_wren=0, and count toward o_fifo_count.
- **Pending flags:** o_rsN_pending = (addr≠0) && (addr matches a live FIFO entry, or o_rd_wren=1 with o_rd_addr==addr). The flags are combinational.
- **Idle:** with no ALU write and nothing to drain, o_rd_wren=0. o_rd_addr and o_rd_data hold their previous values.

## Timing
- **Reset:** o_rd_wren=0, o_rd_addr=0, o_rd_data=0, o_fifo_count=0, o_lsu_ready=1, pending flags 0. All FIFO live bits are cleared.
- **Reset mid-operation:** all queued results are discarded with no write issued. Reset takes effect immediately because it is asynchronous.
- **Latencies:**
  - ALU write: 1 cycle (valid at edge N → o_rd_wren at N+1).
  - LSU bypass: 1 cycle.
  - LSU queued: at least 2 cycles, plus one cycle for every ALU-busy cycle that blocks the drain.
- **Throughput:** one write per cycle. Under continuous ALU writes the LSU stream drains no entries and stalls once DEPTH entries are queued.
- **Pointers:** read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Full and empty are decided from count, not from pointer equality.

## Structure
- Package wb_pkg holds:
  - typedef wb_req_t {logic live; logic [4:0] rd; logic [31:0] data;}
  - localparam REG_X0 = 5'd0
- Sub-module wb_fifo (parameter DEPTH) provides:
  - Storage and pointers.
  - Count and the per-entry squash port, which takes an ALU rd and a strobe.
  - A flattened rd/live view used for the pending comparison.
- wb_arbiter holds the select logic, the output register and the pending comparators.

## Test plan
- **Reset mid-operation:** queue 3 LSU entries, pulse i_reset low → no write occurs, o_fifo_count=0, o_lsu_ready=1, outputs all 0.
- **ALU path:** ALU rd=5 data=0x0000_1234 at N → at N+1, o_rd_wren=1, o_rd_addr=5, o_rd_data=0x0000_1234. o_rs1_pending=1 for rs1=5 during N+1 only.
- **LSU bypass:** FIFO empty, no ALU, LSU rd=7 data=0xDEAD_BEEF at N → written at N+1, o_fifo_count stays 0.
- **Collision:** ALU rd=3 and LSU rd=4 at N → rd 3 written at N+1, rd 4 written at N+2. o_rs2_pending=1 for rs2=4 from N+1 through N+2.
- **Backpressure:** ALU writes rd=1 every cycle for 8 cycles while LSU offers rd=10..14 → o_lsu_ready drops after 4 accepts. Once the ALU stops, rd 10,11,12,13 drain in order, then 14 is accepted and written.
- **Squash and x0:**
  - LSU rd=9 data=0xAA is queued, then ALU writes rd=9 data=0xBB → only 0xBB is written to x9, and the pending flag for 9 clears once 0xBB leaves the output register.
  - ALU or LSU rd=0 → o_rd_wren never asserts for it.
